// File: rtl/three_of_six_decoder.sv
// Symbol-serial 3-of-6 receiver: reassembles 8 six-bit symbols into a 24-bit word.
// THREE_OF_SIX_WEIGHT_CHECK_EN enables the per-symbol weight check, word_err and err_count.
module three_of_six_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [5:0]  sym_in,
  input  logic        sym_valid,
  output logic        sym_ready,
  output logic [23:0] payload,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        word_err,
  output logic [7:0]  err_count
);

  localparam int NSYM  = 8;
  localparam int DAT_W = 3;
  localparam int PAY_W = NSYM * DAT_W;

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t             r_state, w_state_nxt;
  logic [2:0]         r_idx;
  logic [PAY_W-1:0]   r_shadow;
  logic [PAY_W-1:0]   r_payload;
  logic               r_word_valid;
  logic               w_accept;
  logic               w_last;
  logic               w_handoff;
  logic               w_clear;

  // Ready depends only on state and flush so upstream never sees a combinational loop.
  assign sym_ready  = (r_state == COLLECT) && !flush && !rst;
  assign payload    = r_payload;
  assign word_valid = r_word_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= COLLECT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_handoff   = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      COLLECT: begin
        w_clear  = flush;
        w_accept = sym_valid && sym_ready;
        w_last   = w_accept && (r_idx == 3'd7);
        if (w_last) w_state_nxt = HOLD;
      end
      HOLD: begin
        if (r_word_valid && word_ready) begin
          w_handoff   = 1'b1;
          w_state_nxt = COLLECT;
        end
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx        <= '0;
      r_shadow     <= '0;
      r_payload    <= '0;
      r_word_valid <= 1'b0;
    end else begin
      if (w_clear) begin
        r_idx    <= '0;
        r_shadow <= '0;
      end else if (w_last) begin
        r_payload    <= {sym_in[5:3], r_shadow[PAY_W-DAT_W-1:0]};
        r_word_valid <= 1'b1;
        r_idx        <= '0;
        r_shadow     <= '0;
      end else if (w_accept) begin
        r_shadow[DAT_W*r_idx +: DAT_W] <= sym_in[5:3];
        r_idx                          <= r_idx + 3'd1;
      end
      if (w_handoff) r_word_valid <= 1'b0;
    end
  end

`ifdef THREE_OF_SIX_WEIGHT_CHECK_EN
  logic       w_bad;
  logic       r_sticky;
  logic       r_word_err;
  logic [7:0] r_err_count;

  // Bad symbols still land in the payload; only the flag records them.
  assign w_bad     = ($countones(sym_in) != 3);
  assign word_err  = r_word_err;
  assign err_count = r_err_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sticky   <= 1'b0;
      r_word_err <= 1'b0;
    end else if (w_clear) begin
      r_sticky <= 1'b0;
    end else if (w_last) begin
      r_word_err <= r_sticky | w_bad;
      r_sticky   <= 1'b0;
    end else if (w_accept) begin
      r_sticky <= r_sticky | w_bad;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                r_err_count <= '0;
    else if (w_handoff && r_word_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
  end
`else
  logic w_unused_bal;
  assign w_unused_bal = ^sym_in[2:0];
  assign word_err     = 1'b0;
  assign err_count    = 8'd0;
`endif

endmodule

// File: tb/tb_three_of_six_decoder.sv
// Directed bench for three_of_six_decoder; inputs change on negedge, outputs checked there.
module tb_three_of_six_decoder;

`ifdef THREE_OF_SIX_WEIGHT_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [5:0]  sym_in;
  logic        sym_valid;
  logic        sym_ready;
  logic [23:0] payload;
  logic        word_valid;
  logic        word_ready;
  logic        word_err;
  logic [7:0]  err_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  three_of_six_decoder dut (
    .clk(clk), .rst(rst), .flush(flush), .sym_in(sym_in), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .payload(payload), .word_valid(word_valid),
    .word_ready(word_ready), .word_err(word_err), .err_count(err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Append balance bits so the symbol has exactly three ones.
  function automatic logic [5:0] enc(input logic [2:0] d);
    int w;
    logic [2:0] b;
    w = int'(d[0]) + int'(d[1]) + int'(d[2]);
    b = (w == 0) ? 3'b111 : (w == 1) ? 3'b011 : (w == 2) ? 3'b001 : 3'b000;
    return {d, b};
  endfunction

  task automatic put_sym(input logic [5:0] s);
    sym_valid = 1'b1;
    sym_in    = s;
    #1;
    chk("sym_ready_collect", sym_ready, 1'b1);
    @(negedge clk);
    sym_valid = 1'b0;
  endtask

  task automatic send_word(input logic [23:0] p, input int bk, input logic [5:0] bs);
    for (int k = 0; k < 8; k++)
      put_sym((k == bk) ? bs : enc(p[3*k +: 3]));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; sym_valid = 1'b0; sym_in = '0; word_ready = 1'b0;
    #1;
    chk("rst_sym_ready", sym_ready, 1'b0);
    chk("rst_word_valid", word_valid, 1'b0);
    chk("rst_payload", payload, 24'h0);
    chk("rst_err_count", err_count, 8'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_sym_ready", sym_ready, 1'b1);

    // Clean word, continuous flow
    word_ready = 1'b1;
    send_word(24'hABCDEF, -1, 6'h0);
    chk("clean_valid", word_valid, 1'b1);
    chk("clean_payload", payload, 24'hABCDEF);
    chk("clean_err", word_err, 1'b0);
    chk("clean_hold_ready", sym_ready, 1'b0);
    @(negedge clk);
    chk("clean_valid_1cyc", word_valid, 1'b0);
    chk("clean_resume", sym_ready, 1'b1);

    // Weight error in symbol 3; data bits pass through
    send_word(24'h123456, 3, 6'b111_001);
    chk("werr_valid", word_valid, 1'b1);
    chk("werr_payload", payload, 24'h123E56);
    chk("werr_err", word_err, CHK_EN);
    chk("werr_cnt_before", err_count, 8'd0);
    @(negedge clk);
    chk("werr_cnt_after", err_count, CHK_EN ? 8'd1 : 8'd0);

    // Backpressure, with a symbol and a flush offered while holding
    word_ready = 1'b0;
    send_word(24'h5A5A5A, -1, 6'h0);
    sym_valid = 1'b1;
    sym_in    = enc(3'd7);
    for (int i = 0; i < 5; i++) begin
      flush = (i == 2);
      #1;
      chk("bp_valid", word_valid, 1'b1);
      chk("bp_payload", payload, 24'h5A5A5A);
      chk("bp_sym_ready", sym_ready, 1'b0);
      @(negedge clk);
    end
    flush = 1'b0;
    word_ready = 1'b1;
    chk("bp_valid_6th", word_valid, 1'b1);
    @(negedge clk);
    sym_valid = 1'b0;
    chk("bp_released", word_valid, 1'b0);
    send_word(24'h0F0F0F, -1, 6'h0);
    chk("bp_next_payload", payload, 24'h0F0F0F);
    chk("bp_next_valid", word_valid, 1'b1);
    @(negedge clk);

    // Flush discards a partial word containing a bad symbol
    for (int k = 0; k < 5; k++) put_sym((k == 1) ? 6'b111111 : enc(3'd7));
    flush = 1'b1; sym_valid = 1'b1; sym_in = enc(3'd0);
    #1;
    chk("flush_sym_ready", sym_ready, 1'b0);
    @(negedge clk);
    flush = 1'b0; sym_valid = 1'b0;
    send_word(24'h123456, -1, 6'h0);
    chk("flush_valid", word_valid, 1'b1);
    chk("flush_payload", payload, 24'h123456);
    chk("flush_err", word_err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("flush_single_out", word_valid, 1'b0);

    // Asynchronous reset mid-word
    for (int k = 0; k < 3; k++) put_sym(6'b000111 ^ 6'(k));
    #2 rst = 1'b1;
    #1;
    chk("arst_payload", payload, 24'h0);
    chk("arst_valid", word_valid, 1'b0);
    chk("arst_err", word_err, 1'b0);
    chk("arst_cnt", err_count, 8'd0);
    chk("arst_sym_ready", sym_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    send_word(24'hABCDEF, -1, 6'h0);
    chk("arst_next_payload", payload, 24'hABCDEF);
    chk("arst_next_err", word_err, 1'b0);
    @(negedge clk);

    // Saturation of err_count
    for (int i = 0; i < 260; i++) begin
      send_word(24'h000000, 0, 6'b000000);
      if (i == 259) chk("sat_err", word_err, CHK_EN);
      @(negedge clk);
      if (i == 199) chk("sat_cnt_200", err_count, CHK_EN ? 8'd200 : 8'd0);
      if (i == 254) chk("sat_cnt_255", err_count, CHK_EN ? 8'd255 : 8'd0);
    end
    chk("sat_cnt_held", err_count, CHK_EN ? 8'd255 : 8'd0);
    chk("sat_idle", word_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
